mem_arbiter: RTL and testbench

- Sits directly downstream of request_unit and the fetch stage, and upstream of the single-ported RAM.
- Accepts the instruction-fetch request (iren) and the data requests (dmemren/dmemwen), grants one at a time, and drives the RAM strobes.
- Returns the ihit/dhit pulses and load data that the request unit and pipeline consume.
- Includes a per-access timeout so a stuck RAM cannot hang the pipeline.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_if.sv | 35 +++
 rtl/mem_arbiter_wait_timer.sv | 28 ++
 rtl/mem_arbiter.sv | 89 ++++++++
 tb/tb_mem_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
//   arb_state_t : arbiter FSM states
//   addr_t      : default-width RAM address
//   word_t      : default-width RAM data word
//   ALIGN_MASK  : clears the byte-offset bits of an address
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef logic [DEF_ADDR_W-1:0] addr_t;
  typedef logic [DEF_DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam addr_t ALIGN_MASK = ~addr_t'(3);

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: requester-side and RAM-side signals of the memory arbiter.
//   slave  : arbiter view (takes requests and RAM replies, drives hits and strobes)
//   master : requester/RAM-model view (the opposite directions)
interface mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iren;
  logic [ADDR_W-1:0] iaddr;
  logic              dmemren;
  logic              dmemwen;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              ihit;
  logic              dhit;
  logic [DATA_W-1:0] iload;
  logic [DATA_W-1:0] dload;
  logic              err;
  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] ram_load;
  logic              ram_ready;

  modport slave (
    input  iren, iaddr, dmemren, dmemwen, daddr, dstore, ram_load, ram_ready,
    output ihit, dhit, iload, dload, err, ram_ren, ram_wen, ram_addr, ram_store
  );

  modport master (
    output iren, iaddr, dmemren, dmemwen, daddr, dstore, ram_load, ram_ready,
    input  ihit, dhit, iload, dload, err, ram_ren, ram_wen, ram_addr, ram_store
  );
endinterface

// File: rtl/mem_arbiter_wait_timer.sv
// wait_timer: counts cycles spent in an access state.
//   i_clk, i_rst : clock, async active-high reset
//   i_clear      : return count to 0
//   i_enable     : count this cycle
//   o_done       : this enabled cycle brings the count to TIMEOUT
module wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_done
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_count;

  // Flag on the cycle whose increment reaches TIMEOUT, so the FSM leaves the
  // access state after exactly TIMEOUT access cycles.
  assign o_done = i_enable && (r_count == W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_count <= '0;
    else if (i_clear)  r_count <= '0;
    else if (i_enable) r_count <= r_count + 1'b1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants data or fetch requests one at a time to a single-ported
// RAM, returns one-cycle hit pulses with load data, and forces completion with
// err after TIMEOUT access cycles without ram_ready.
//   CLK, RST : clock, async active-high reset
//   bus      : mem_arb_if.slave (requests, hits, loads, err, RAM strobes/data)
// All outputs are registered.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RST,
  mem_arb_if.slave   bus
);
  localparam logic [ADDR_W-1:0] W_MASK = ~ADDR_W'(~ALIGN_MASK);

  arb_state_t r_state;
  logic       w_in_acc;
  logic       w_done;

  assign w_in_acc = (r_state == DACC) || (r_state == IACC);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_clear  (!w_in_acc),
    .i_enable (w_in_acc),
    .o_done   (w_done)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= IDLE;
      bus.ihit      <= 1'b0;
      bus.dhit      <= 1'b0;
      bus.iload     <= '0;
      bus.dload     <= '0;
      bus.err       <= 1'b0;
      bus.ram_ren   <= 1'b0;
      bus.ram_wen   <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_store <= '0;
    end else begin
      // hits and err are single-cycle pulses
      bus.ihit <= 1'b0;
      bus.dhit <= 1'b0;
      bus.err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.dmemwen || bus.dmemren) begin
            r_state      <= DACC;
            bus.ram_addr <= bus.daddr & W_MASK;
            // write wins when both data strobes are (illegally) high
            if (bus.dmemwen) begin
              bus.ram_wen   <= 1'b1;
              bus.ram_store <= bus.dstore;
            end else begin
              bus.ram_ren <= 1'b1;
            end
          end else if (bus.iren) begin
            r_state      <= IACC;
            bus.ram_addr <= bus.iaddr & W_MASK;
            bus.ram_ren  <= 1'b1;
          end
        end
        DACC, IACC: begin
          if (bus.ram_ready || w_done) begin
            r_state     <= RESP;
            bus.ram_ren <= 1'b0;
            bus.ram_wen <= 1'b0;
            bus.err     <= !bus.ram_ready;
            if (r_state == DACC) bus.dhit <= 1'b1;
            else                 bus.ihit <= 1'b1;
            if (bus.ram_ren) begin
              if (r_state == DACC) bus.dload <= bus.ram_ready ? bus.ram_load : '0;
              else                 bus.iload <= bus.ram_ready ? bus.ram_load : '0;
            end
          end
        end
        // RESP ignores requests so a requester gets one edge to drop its strobe
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int TMO = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // observations of one access, filled by access()
  int    o_cycles, o_lat, o_hitk;
  bit    o_hung, o_stable, o_both;
  logic  o_ren, o_wen, o_ihit, o_dhit, o_err;
  addr_t o_addr;
  word_t o_store, o_iload, o_dload, o_dload_after;
  logic  o_resp_strobe, o_after_hit, o_after_err, o_after_strobe;

  // Issue a request at the current negedge, play a RAM that raises ram_ready
  // in access cycle delay+1, and record what the arbiter did. Returns at the
  // negedge of the cycle after the hit.
  task automatic access(input bit dr, input bit dw, input bit ir,
                        input addr_t ad, input addr_t ai, input word_t st,
                        input int delay, input word_t rd,
                        input bit hold_d, input bit hold_i);
    bus.dmemren = dr; bus.dmemwen = dw; bus.iren = ir;
    bus.daddr = ad; bus.iaddr = ai; bus.dstore = st;
    bus.ram_ready = 1'b0; bus.ram_load = $urandom;
    o_cycles = 0; o_lat = 0; o_hitk = 0; o_hung = 1; o_stable = 1; o_both = 0;
    o_ren = 0; o_wen = 0; o_addr = '0; o_store = '0;
    o_ihit = 0; o_dhit = 0; o_err = 0; o_iload = '0; o_dload = '0;
    o_resp_strobe = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge CLK);
      if (bus.ihit && bus.dhit) o_both = 1;
      if (bus.ihit || bus.dhit) begin
        o_hung = 0; o_hitk = k;
        o_ihit = bus.ihit; o_dhit = bus.dhit; o_err = bus.err;
        o_iload = bus.iload; o_dload = bus.dload;
        o_resp_strobe = bus.ram_ren | bus.ram_wen;
        break;
      end
      if (bus.ram_ren || bus.ram_wen) begin
        if (o_cycles == 0) begin
          o_lat = k; o_ren = bus.ram_ren; o_wen = bus.ram_wen;
          o_addr = bus.ram_addr; o_store = bus.ram_store;
        end else if (bus.ram_ren !== o_ren || bus.ram_wen !== o_wen ||
                     bus.ram_addr !== o_addr || bus.ram_store !== o_store) begin
          o_stable = 0;
        end
        o_cycles++;
        bus.ram_ready = (o_cycles == delay + 1);
        bus.ram_load  = (o_cycles == delay + 1) ? rd : word_t'($urandom);
        // requester-side inputs must be ignored during the access
        bus.daddr = $urandom; bus.iaddr = $urandom; bus.dstore = $urandom;
      end
    end
    bus.ram_ready = 1'b0;
    if (!hold_d) begin bus.dmemren = 0; bus.dmemwen = 0; end
    if (!hold_i) bus.iren = 0;
    @(negedge CLK);
    if (bus.ihit && bus.dhit) o_both = 1;
    o_after_hit = bus.ihit | bus.dhit;
    o_after_err = bus.err;
    o_after_strobe = bus.ram_ren | bus.ram_wen;
    o_dload_after = bus.dload;
  endtask

  task automatic test_reset();
    bus.iren = 0; bus.dmemren = 0; bus.dmemwen = 0; bus.iaddr = '0;
    bus.daddr = '0; bus.dstore = '0; bus.ram_load = '0; bus.ram_ready = 0;
    RST = 1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({bus.ihit, bus.dhit, bus.iload, bus.dload, bus.err, bus.ram_ren,
         bus.ram_wen, bus.ram_addr, bus.ram_store} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero outputs required all 0");
    end
    RST = 0;
    @(negedge CLK);
    checks++;
    if ((bus.ram_ren | bus.ram_wen | bus.ihit | bus.dhit) !== 1'b0) begin
      errors++; $display("FAIL idle_no_req got activity required none");
    end
  endtask

  task automatic test_read_with_fetch();
    access(1, 0, 1, 32'h44, 32'h08, '0, 3, 32'hDEADBEEF, 0, 1);
    checks++; if (o_hitk !== 5) begin errors++; $display("FAIL rdf_hit_cycle got %0d required 5", o_hitk); end
    checks++; if ({o_dhit, o_ihit, o_err} !== 3'b100) begin errors++; $display("FAIL rdf_data_first got d%b i%b e%b required d1 i0 e0", o_dhit, o_ihit, o_err); end
    checks++; if (o_dload !== 32'hDEADBEEF) begin errors++; $display("FAIL rdf_dload got %h required deadbeef", o_dload); end
    checks++; if ({o_ren, o_wen, o_addr} !== {2'b10, 32'h44}) begin errors++; $display("FAIL rdf_strobe got r%b w%b a%h required r1 w0 a00000044", o_ren, o_wen, o_addr); end
    checks++; if (o_after_strobe !== 0 || o_dload_after !== 32'hDEADBEEF) begin errors++; $display("FAIL rdf_after got strobe %b dload %h required 0 deadbeef", o_after_strobe, o_dload_after); end
    access(0, 0, 1, '0, 32'h08, '0, 0, 32'hCAFEF00D, 0, 0);
    checks++; if (o_lat !== 1 || o_addr !== 32'h08) begin errors++; $display("FAIL rdf_fetch_grant got lat %0d addr %h required 1 00000008", o_lat, o_addr); end
    checks++; if ({o_ihit, o_dhit, o_hitk} !== {2'b10, 32'd2}) begin errors++; $display("FAIL rdf_ihit got i%b d%b k%0d required i1 d0 k2", o_ihit, o_dhit, o_hitk); end
    checks++; if (o_iload !== 32'hCAFEF00D || o_both !== 0) begin errors++; $display("FAIL rdf_iload got %h both %b required cafef00d 0", o_iload, o_both); end
  endtask

  task automatic test_reset_mid();
    bus.dmemwen = 1; bus.daddr = 32'h100; bus.dstore = 32'h55; bus.ram_ready = 0;
    repeat (3) @(negedge CLK);
    checks++; if (bus.ram_wen !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got wen %b required 1", bus.ram_wen); end
    #2 RST = 1;
    #1;
    checks++;
    if ({bus.ihit, bus.dhit, bus.iload, bus.dload, bus.err, bus.ram_ren,
         bus.ram_wen, bus.ram_addr, bus.ram_store} !== '0) begin
      errors++; $display("FAIL rst_mid_async got wen %b addr %h dload %h iload %h required all 0",
                         bus.ram_wen, bus.ram_addr, bus.dload, bus.iload);
    end
    bus.dmemwen = 0;
    @(negedge CLK);
    RST = 0;
    @(negedge CLK);
    checks++; if ((bus.ram_ren | bus.ram_wen | bus.dhit) !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got activity required none"); end
  endtask

  task automatic test_write();
    access(0, 1, 0, 32'h203, '0, 32'h12345678, 2, 32'h0, 0, 0);
    checks++; if ({o_wen, o_ren, o_addr} !== {2'b10, 32'h200}) begin errors++; $display("FAIL wr_strobe got w%b r%b a%h required w1 r0 a00000200", o_wen, o_ren, o_addr); end
    checks++; if (o_store !== 32'h12345678 || o_stable !== 1) begin errors++; $display("FAIL wr_store got %h stable %b required 12345678 1", o_store, o_stable); end
    checks++; if (o_cycles !== 3) begin errors++; $display("FAIL wr_cycles got %0d required 3", o_cycles); end
    checks++; if ({o_dhit, o_err, o_resp_strobe, o_after_hit} !== 4'b1000) begin errors++; $display("FAIL wr_hit got d%b e%b s%b after%b required 1 0 0 0", o_dhit, o_err, o_resp_strobe, o_after_hit); end
  endtask

  task automatic test_timeout();
    access(0, 0, 1, '0, 32'h1004, '0, 50, 32'h0BAD0BAD, 0, 0);
    checks++; if (o_hung !== 0 || o_hitk !== TMO + 1) begin errors++; $display("FAIL tmo_hit_cycle got hung %b k %0d required 0 %0d", o_hung, o_hitk, TMO + 1); end
    checks++; if (o_cycles !== TMO) begin errors++; $display("FAIL tmo_cycles got %0d required %0d", o_cycles, TMO); end
    checks++; if ({o_ihit, o_err, o_iload} !== {2'b11, 32'h0}) begin errors++; $display("FAIL tmo_err got i%b e%b load %h required 1 1 0", o_ihit, o_err, o_iload); end
    checks++; if ({o_resp_strobe, o_after_err, o_after_hit} !== 3'b000) begin errors++; $display("FAIL tmo_drop got s%b e%b h%b required 0 0 0", o_resp_strobe, o_after_err, o_after_hit); end
  endtask

  task automatic test_hold_request();
    access(1, 0, 0, 32'h300, '0, '0, 0, 32'hA5A5A5A5, 1, 0);
    checks++; if (o_dhit !== 1 || o_after_strobe !== 0) begin errors++; $display("FAIL hold_no_regrant got dhit %b strobe_after %b required 1 0", o_dhit, o_after_strobe); end
    access(1, 0, 0, 32'h304, '0, '0, 1, 32'h5A5A5A5A, 0, 0);
    checks++; if (o_lat !== 1 || o_addr !== 32'h304) begin errors++; $display("FAIL hold_regrant got lat %0d addr %h required 1 00000304", o_lat, o_addr); end
    checks++; if (o_dload !== 32'h5A5A5A5A || o_hitk !== 3) begin errors++; $display("FAIL hold_second got %h k %0d required 5a5a5a5a 3", o_dload, o_hitk); end
  endtask

  task automatic test_illegal_both();
    access(1, 1, 0, 32'h40, '0, 32'hFEEDFACE, 2, 32'h1, 0, 0);
    checks++; if ({o_wen, o_ren, o_stable} !== 3'b101) begin errors++; $display("FAIL both_write got w%b r%b stable %b required 1 0 1", o_wen, o_ren, o_stable); end
    checks++; if (o_store !== 32'hFEEDFACE || o_dhit !== 1) begin errors++; $display("FAIL both_store got %h dhit %b required feedface 1", o_store, o_dhit); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int    kind, delay, exp_n;
      bit    dr, dw, ir, exp_err;
      addr_t ad, ai, exp_addr;
      word_t st, rd, exp_load, got_load;
      kind  = $urandom_range(0, 2);
      delay = $urandom_range(0, 6);
      ad = $urandom; ai = $urandom; st = $urandom; rd = $urandom;
      dr = (kind == 0); dw = (kind == 1);
      ir = (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      exp_n    = (delay + 1 < TMO) ? delay + 1 : TMO;
      exp_err  = (delay + 1 > TMO);
      exp_load = exp_err ? '0 : rd;
      exp_addr = {(kind == 2 ? ai[31:2] : ad[31:2]), 2'b00};
      access(dr, dw, ir, ad, ai, st, delay, rd, 0, 0);
      got_load = (kind == 2) ? o_iload : o_dload;
      checks++; if (o_hung !== 0 || o_lat !== 1) begin errors++; $display("FAIL rnd_grant n%0d got hung %b lat %0d required 0 1", n, o_hung, o_lat); end
      checks++; if (o_cycles !== exp_n || o_hitk !== exp_n + 1) begin errors++; $display("FAIL rnd_cycles n%0d got %0d k%0d required %0d k%0d", n, o_cycles, o_hitk, exp_n, exp_n + 1); end
      checks++; if ({o_ren, o_wen} !== {kind != 1, kind == 1} || o_addr !== exp_addr || o_stable !== 1) begin errors++; $display("FAIL rnd_strobe n%0d got r%b w%b a%h s%b required a%h", n, o_ren, o_wen, o_addr, o_stable, exp_addr); end
      checks++; if ({o_ihit, o_dhit, o_err} !== {kind == 2, kind != 2, exp_err}) begin errors++; $display("FAIL rnd_hit n%0d got i%b d%b e%b required kind %0d err %b", n, o_ihit, o_dhit, o_err, kind, exp_err); end
      checks++; if ({o_both, o_resp_strobe, o_after_hit, o_after_err} !== 4'b0000) begin errors++; $display("FAIL rnd_pulse n%0d got both%b s%b h%b e%b required 0000", n, o_both, o_resp_strobe, o_after_hit, o_after_err); end
      if (kind == 1) begin
        checks++; if (o_store !== st) begin errors++; $display("FAIL rnd_store n%0d got %h required %h", n, o_store, st); end
      end else begin
        checks++; if (got_load !== exp_load) begin errors++; $display("FAIL rnd_load n%0d got %h required %h", n, got_load, exp_load); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_with_fetch();
    test_reset_mid();
    test_write();
    test_timeout();
    test_hold_request();
    test_illegal_both();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
